// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking-neuron datapath blocks.
// Holds the accumulator FSM state encoding, a constant clog2 and a signed clamp.
// Pure package: no logic, no timing.
package snn_pkg;

  localparam int DEF_WW    = 2;
  localparam int DEF_OUT_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_e;

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Clamp a signed value into the range of a w-bit signed number.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/weighted_lane_adder.sv
// Sums LANES spike-gated signed weights into one ACC_W-bit signed partial sum.
// Latency: combinational, zero cycles.
// Backpressure: none; purely a function of its inputs.
module weighted_lane_adder #(
  parameter int LANES = 2,
  parameter int WW    = 2,
  parameter int ACC_W = 7
) (
  input  logic [LANES-1:0]        lane_spikes,
  input  logic [LANES*WW-1:0]     lane_weights,
  output logic signed [ACC_W-1:0] lane_sum
);

  // Each active lane contributes its sign-extended weight; idle lanes add nothing.
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_spikes[i]) begin
        lane_sum = lane_sum + ACC_W'($signed(lane_weights[i*WW +: WW]));
      end
    end
  end

endmodule

// File: rtl/input_current_accumulator.sv
// Accumulates M spike-gated signed weights, LANES per cycle, into a saturated/wrapped current.
// Latency: out_valid rises NBEATS = ceil(M/LANES) cycles after the accepting edge.
// Backpressure: one vector in flight; result held in DONE until out_ready, in_ready only in IDLE.
module input_current_accumulator
  import snn_pkg::*;
#(
  parameter int M        = 8,
  parameter int WW       = DEF_WW,
  parameter int LANES    = 2,
  parameter int OUT_W    = DEF_OUT_W,
  parameter int SATURATE = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [M-1:0]       input_spikes,
  input  logic [M*WW-1:0]    weights,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   input_current,
  output logic               overflow
);

  localparam int NBEATS = (M + LANES - 1) / LANES;
  // Captured vectors are padded to a whole number of beats; pad spikes are 0 so they add nothing.
  localparam int PAD_N  = NBEATS * LANES;
  localparam int ACC_W  = WW + clog2(M + 1) + 1;
  localparam int BEAT_W = (clog2(NBEATS) > 0) ? clog2(NBEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);
  localparam logic signed [31:0] OUT_MAX = (32'sd1 <<< (OUT_W - 1)) - 32'sd1;
  localparam logic signed [31:0] OUT_MIN = -(32'sd1 <<< (OUT_W - 1));

  acc_state_e               state_q,   state_d;
  logic [BEAT_W-1:0]        beat_q,    beat_d;
  logic signed [ACC_W-1:0]  acc_q,     acc_d;
  logic [PAD_N-1:0]         spikes_q,  spikes_d;
  logic [PAD_N*WW-1:0]      weights_q, weights_d;
  logic [OUT_W-1:0]         cur_q,     cur_d;
  logic                     ovf_q,     ovf_d;

  logic [LANES-1:0]         lane_spk;
  logic [LANES*WW-1:0]      lane_wt;
  logic signed [ACC_W-1:0]  lane_sum;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [31:0]       acc_ext;
  logic signed [31:0]       sat_val;
  logic [OUT_W-1:0]         cur_map;
  logic                     ovf_map;

  // Select the current beat's slice of the captured vectors with constant indices.
  always_comb begin
    lane_spk = '0;
    lane_wt  = '0;
    for (int b = 0; b < NBEATS; b++) begin
      if (beat_q == BEAT_W'(b)) begin
        lane_spk = spikes_q[b*LANES +: LANES];
        lane_wt  = weights_q[b*LANES*WW +: LANES*WW];
      end
    end
  end

  weighted_lane_adder #(
    .LANES (LANES),
    .WW    (WW),
    .ACC_W (ACC_W)
  ) u_lane_adder (
    .lane_spikes  (lane_spk),
    .lane_weights (lane_wt),
    .lane_sum     (lane_sum)
  );

  // Running sum and its mapping onto the OUT_W signed output range.
  always_comb begin
    acc_sum = acc_q + lane_sum;
    acc_ext = 32'(acc_sum);
    sat_val = sat_signed(acc_ext, OUT_W);
    ovf_map = (acc_ext > OUT_MAX) || (acc_ext < OUT_MIN);
    cur_map = (SATURATE != 0) ? OUT_W'(sat_val) : OUT_W'(acc_ext);
  end

  // FSM next-state: capture in IDLE, one beat per cycle in ACCUM, hold result in DONE.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    acc_d     = acc_q;
    spikes_d  = spikes_q;
    weights_d = weights_q;
    cur_d     = cur_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          spikes_d  = PAD_N'(input_spikes);
          weights_d = (PAD_N*WW)'(weights);
          acc_d     = '0;
          beat_d    = '0;
          state_d   = ACCUM;
        end
      end
      ACCUM: begin
        acc_d  = acc_sum;
        beat_d = beat_q + BEAT_W'(1);
        if (beat_q == LAST_BEAT) begin
          cur_d   = cur_map;
          ovf_d   = ovf_map;
          beat_d  = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any vector in flight and clears the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      acc_q     <= '0;
      spikes_q  <= '0;
      weights_q <= '0;
      cur_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      acc_q     <= acc_d;
      spikes_q  <= spikes_d;
      weights_q <= weights_d;
      cur_q     <= cur_d;
      ovf_q     <= ovf_d;
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign out_valid     = (state_q == DONE);
  assign input_current = cur_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_input_current_accumulator.sv
// Scoreboard bench: five parameterisations share one stimulus stream.
// Expected results come from an arithmetic model of the weighted sum.
// A forked monitor pops and compares on every output handshake.
module tb_input_current_accumulator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  spikes = '0;
  logic [15:0] weights = '0;
  logic [4:0]  in_rdy;
  logic [4:0]  out_vld;
  logic [4:0]  ovf;
  logic [4:0]  cur0, cur3, cur4;
  logic [3:0]  cur1, cur2;

  always #5 clk = ~clk;

  // u0 default, u1 OUT_W=4 saturating, u2 OUT_W=4 wrapping, u3 M=7/LANES=3, u4 LANES=8
  input_current_accumulator #(.M(8), .WW(2), .LANES(2), .OUT_W(5), .SATURATE(1)) u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_rdy[0]),
    .input_spikes(spikes), .weights(weights), .out_valid(out_vld[0]),
    .out_ready(out_ready), .input_current(cur0), .overflow(ovf[0]));
  input_current_accumulator #(.M(8), .WW(2), .LANES(2), .OUT_W(4), .SATURATE(1)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_rdy[1]),
    .input_spikes(spikes), .weights(weights), .out_valid(out_vld[1]),
    .out_ready(out_ready), .input_current(cur1), .overflow(ovf[1]));
  input_current_accumulator #(.M(8), .WW(2), .LANES(2), .OUT_W(4), .SATURATE(0)) u2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_rdy[2]),
    .input_spikes(spikes), .weights(weights), .out_valid(out_vld[2]),
    .out_ready(out_ready), .input_current(cur2), .overflow(ovf[2]));
  input_current_accumulator #(.M(7), .WW(2), .LANES(3), .OUT_W(5), .SATURATE(1)) u3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_rdy[3]),
    .input_spikes(spikes[6:0]), .weights(weights[13:0]), .out_valid(out_vld[3]),
    .out_ready(out_ready), .input_current(cur3), .overflow(ovf[3]));
  input_current_accumulator #(.M(8), .WW(2), .LANES(8), .OUT_W(5), .SATURATE(1)) u4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_rdy[4]),
    .input_spikes(spikes), .weights(weights), .out_valid(out_vld[4]),
    .out_ready(out_ready), .input_current(cur4), .overflow(ovf[4]));

  typedef struct {
    int cur;
    int ovf;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t q3[$];
  exp_t q4[$];

  int n_checks = 0;
  int n_pass   = 0;
  bit ordy_rand = 1'b0;

  // Reference: exact signed sum of gated weights, then clamp or wrap to ow bits.
  function automatic exp_t model(input logic [7:0] sp, input logic [15:0] w,
                                 input int m, input int ow, input int sat);
    exp_t e;
    int   sum;
    int   wi;
    int   hi;
    int   lo;
    int   v;
    sum = 0;
    hi  = (1 << (ow - 1)) - 1;
    lo  = -(1 << (ow - 1));
    for (int i = 0; i < m; i++) begin
      if (sp[i]) begin
        wi = int'(w[2*i +: 2]);
        if (wi >= 2) wi = wi - 4;
        sum = sum + wi;
      end
    end
    e.ovf = (sum > hi || sum < lo) ? 1 : 0;
    if (sat != 0) begin
      e.cur = (sum > hi) ? hi : ((sum < lo) ? lo : sum);
    end else begin
      v = sum & ((1 << ow) - 1);
      if (v > hi) v = v - (1 << ow);
      e.cur = v;
    end
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic pop_check(input int idx, input int cur, input int ov);
    exp_t e;
    int   sz;
    case (idx)
      0: sz = q0.size();
      1: sz = q1.size();
      2: sz = q2.size();
      3: sz = q3.size();
      default: sz = q4.size();
    endcase
    chk($sformatf("u%0d_output_expected", idx), (sz > 0) ? 1 : 0, 1);
    if (sz > 0) begin
      case (idx)
        0: e = q0.pop_front();
        1: e = q1.pop_front();
        2: e = q2.pop_front();
        3: e = q3.pop_front();
        default: e = q4.pop_front();
      endcase
      chk($sformatf("u%0d_current", idx), cur, e.cur);
      chk($sformatf("u%0d_overflow", idx), ov, e.ovf);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!reset && out_ready) begin
        if (out_vld[0]) pop_check(0, int'($signed(cur0)), int'(ovf[0]));
        if (out_vld[1]) pop_check(1, int'($signed(cur1)), int'(ovf[1]));
        if (out_vld[2]) pop_check(2, int'($signed(cur2)), int'(ovf[2]));
        if (out_vld[3]) pop_check(3, int'($signed(cur3)), int'(ovf[3]));
        if (out_vld[4]) pop_check(4, int'($signed(cur4)), int'(ovf[4]));
      end
    end
  endtask

  function automatic int pending();
    return q0.size() + q1.size() + q2.size() + q3.size() + q4.size();
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (ordy_rand) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [7:0] sp, input logic [15:0] w);
    int guard;
    guard = 0;
    while (in_rdy != 5'h1F && guard < 300) begin
      tick();
      guard++;
    end
    if (in_rdy != 5'h1F) begin
      chk("send_ready_timeout", int'(in_rdy), 31);
    end else begin
      spikes   = sp;
      weights  = w;
      in_valid = 1'b1;
      q0.push_back(model(sp, w, 8, 5, 1));
      q1.push_back(model(sp, w, 8, 4, 1));
      q2.push_back(model(sp, w, 8, 4, 0));
      q3.push_back(model(sp, w, 7, 5, 1));
      q4.push_back(model(sp, w, 8, 5, 1));
      tick();
      in_valid = 1'b0;
      // Scramble the inputs: the DUT must work from its captured copy.
      spikes   = 8'($urandom);
      weights  = 16'($urandom);
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (pending() != 0 && guard < 600) begin
      tick();
      guard++;
    end
    chk("drain_pending", pending(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   lat;
    int   guard;
    fork
      monitor();
    join_none

    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("reset_in_ready", int'(in_rdy), 31);
    chk("reset_out_valid", int'(out_vld), 0);
    chk("reset_current", int'(cur0), 0);
    chk("reset_overflow", int'(ovf), 0);

    // All weights +1, all spikes: latency and sums (saturate and wrap at OUT_W=4)
    out_ready = 1'b1;
    send(8'hFF, 16'h5555);
    lat = 0;
    while (!out_vld[0] && lat < 50) begin
      tick();
      lat++;
    end
    chk("latency_u0", lat, 4);
    drain();

    // All weights -2, then mixed pattern
    send(8'hFF, 16'hAAAA);
    drain();
    send(8'hA5, 16'h1E4B);
    drain();

    // Backpressure in DONE
    out_ready = 1'b0;
    send(8'h3C, 16'h7D2E);
    e = model(8'h3C, 16'h7D2E, 8, 5, 1);
    guard = 0;
    while (!out_vld[0] && guard < 50) begin
      tick();
      guard++;
    end
    chk("bp_reached_done", int'(out_vld[0]), 1);
    for (int i = 0; i < 10; i++) begin
      chk("bp_current_stable", int'($signed(cur0)), e.cur);
      chk("bp_in_ready_low", int'(in_rdy[0]), 0);
      chk("bp_out_valid_held", int'(out_vld[0]), 1);
      in_valid = (i % 2 == 0);
      spikes   = 8'($urandom);
      weights  = 16'($urandom);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_in_ready", int'(in_rdy[0]), 1);
    chk("bp_release_out_valid", int'(out_vld[0]), 0);
    chk("idle_holds_current", int'($signed(cur0)), e.cur);
    drain();

    // Reset during beat 2 of ACCUM
    send(8'hFF, 16'h5555);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("abort_in_ready", int'(in_rdy), 31);
    chk("abort_out_valid", int'(out_vld), 0);
    chk("abort_current", int'(cur0), 0);
    chk("abort_overflow", int'(ovf[0]), 0);
    q0.delete();
    q1.delete();
    q2.delete();
    q3.delete();
    q4.delete();
    reset = 1'b0;
    tick();
    send(8'h5A, 16'hC3A5);
    drain();

    // Randomised vectors with random downstream stalls
    ordy_rand = 1'b1;
    repeat (40) send(8'($urandom), 16'($urandom));
    drain();
    ordy_rand = 1'b0;
    out_ready = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
